// File: rtl/vga_timing_pkg.sv
// Shared encodings, 1080p defaults and timing-set helpers
// for the VGA raster timing sequencer.
package vga_timing_pkg;

    localparam int COORD_W = 12;
    localparam int SUM_W   = 14;

    typedef enum logic [2:0] {
        CFG_H_ACTIVE = 3'd0,
        CFG_H_FP     = 3'd1,
        CFG_H_SYNC   = 3'd2,
        CFG_H_BP     = 3'd3,
        CFG_V_ACTIVE = 3'd4,
        CFG_V_FP     = 3'd5,
        CFG_V_SYNC   = 3'd6,
        CFG_V_BP     = 3'd7
    } cfg_field_e;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    localparam logic [COORD_W-1:0] HD_H_ACTIVE = 12'd1920;
    localparam logic [COORD_W-1:0] HD_H_FP     = 12'd88;
    localparam logic [COORD_W-1:0] HD_H_SYNC   = 12'd44;
    localparam logic [COORD_W-1:0] HD_H_BP     = 12'd148;
    localparam logic [COORD_W-1:0] HD_V_ACTIVE = 12'd1080;
    localparam logic [COORD_W-1:0] HD_V_FP     = 12'd4;
    localparam logic [COORD_W-1:0] HD_V_SYNC   = 12'd5;
    localparam logic [COORD_W-1:0] HD_V_BP     = 12'd36;

    typedef struct packed {
        logic [COORD_W-1:0] active;
        logic [COORD_W-1:0] fp;
        logic [COORD_W-1:0] sync;
        logic [COORD_W-1:0] bp;
    } axis_cfg_t;

    typedef struct packed {
        axis_cfg_t h;
        axis_cfg_t v;
    } timing_t;

    // Wide enough that four 12-bit fields can never wrap
    function automatic logic [SUM_W-1:0] axis_total(axis_cfg_t a);
        return SUM_W'(a.active) + SUM_W'(a.fp)
             + SUM_W'(a.sync) + SUM_W'(a.bp);
    endfunction

    function automatic logic axis_ok(axis_cfg_t a);
        return (a.active != '0) && (a.fp != '0)
            && (a.sync != '0) && (a.bp != '0)
            && (axis_total(a) <= SUM_W'(4095));
    endfunction

endpackage

// File: rtl/vga_timing_sequencer_axis.sv
// Single raster axis: position counter with wrap at total-1
// plus sync/active decode of the position it will hold next.
module vga_axis_counter
    import vga_timing_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    input  axis_cfg_t          cfg,
    output logic [COORD_W-1:0] cnt,
    output logic [COORD_W-1:0] cnt_nxt,
    output logic               wrap,
    output logic               nxt_sync_n,
    output logic               nxt_active
);

    logic [SUM_W-1:0] total;
    logic [SUM_W-1:0] sync_lo;
    logic [SUM_W-1:0] sync_hi;
    logic [SUM_W-1:0] nxt_w;

    always_comb begin
        total   = axis_total(cfg);
        sync_lo = SUM_W'(cfg.active) + SUM_W'(cfg.fp);
        sync_hi = sync_lo + SUM_W'(cfg.sync);
        wrap    = (SUM_W'(cnt) == total - SUM_W'(1));

        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = wrap ? '0 : cnt + 1'b1;
        end

        nxt_w      = SUM_W'(cnt_nxt);
        nxt_sync_n = !((nxt_w >= sync_lo) && (nxt_w < sync_hi));
        nxt_active = (nxt_w < SUM_W'(cfg.active));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_sequencer.sv
// Raster timing controller: shadowed timing registers applied at
// frame boundaries, H/V counters and registered sync/enable decode.
module vga_timing_sequencer
    import vga_timing_pkg::*;
#(
    parameter logic [COORD_W-1:0] DEF_H_ACTIVE = HD_H_ACTIVE,
    parameter logic [COORD_W-1:0] DEF_H_FP     = HD_H_FP,
    parameter logic [COORD_W-1:0] DEF_H_SYNC   = HD_H_SYNC,
    parameter logic [COORD_W-1:0] DEF_H_BP     = HD_H_BP,
    parameter logic [COORD_W-1:0] DEF_V_ACTIVE = HD_V_ACTIVE,
    parameter logic [COORD_W-1:0] DEF_V_FP     = HD_V_FP,
    parameter logic [COORD_W-1:0] DEF_V_SYNC   = HD_V_SYNC,
    parameter logic [COORD_W-1:0] DEF_V_BP     = HD_V_BP
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_addr,
    input  logic [COORD_W-1:0] cfg_data,
    input  logic               cfg_commit,
    output logic               cfg_pending,
    output logic               cfg_err,
    output logic               h_sync,
    output logic               v_sync,
    output logic               video_enable,
    output logic [COORD_W-1:0] x_idx,
    output logic [COORD_W-1:0] y_idx,
    output logic               line_start,
    output logic               frame_start
);

    localparam timing_t DEF_SET = '{
        h: '{active: DEF_H_ACTIVE, fp: DEF_H_FP,
             sync: DEF_H_SYNC, bp: DEF_H_BP},
        v: '{active: DEF_V_ACTIVE, fp: DEF_V_FP,
             sync: DEF_V_SYNC, bp: DEF_V_BP}
    };

    state_e  state_q;
    state_e  state_d;
    timing_t act_q;
    timing_t shd_q;
    timing_t shd_d;

    logic pending_q;
    logic pending_d;
    logic err_q;
    logic wr_fire;
    logic commit_try;
    logic shd_ok;
    logic commit_ok;
    logic commit_bad;
    logic apply;
    logic go;
    logic cnt_en;

    logic [COORD_W-1:0] h_nxt;
    logic [COORD_W-1:0] v_nxt;
    logic h_wrap;
    logic v_wrap;
    logic h_sn;
    logic v_sn;
    logic h_act;
    logic v_act;

    assign cfg_ready   = !pending_q;
    assign cfg_pending = pending_q;
    assign cfg_err     = err_q;

    // Counters only advance while running and staying running
    assign cnt_en = (state_q != ST_STOP) && run;

    vga_axis_counter u_h (
        .clk        (clk),
        .reset      (reset),
        .clr        (!cnt_en),
        .en         (cnt_en),
        .cfg        (act_q.h),
        .cnt        (x_idx),
        .cnt_nxt    (h_nxt),
        .wrap       (h_wrap),
        .nxt_sync_n (h_sn),
        .nxt_active (h_act)
    );

    vga_axis_counter u_v (
        .clk        (clk),
        .reset      (reset),
        .clr        (!cnt_en),
        .en         (cnt_en && h_wrap),
        .cfg        (act_q.v),
        .cnt        (y_idx),
        .cnt_nxt    (v_nxt),
        .wrap       (v_wrap),
        .nxt_sync_n (v_sn),
        .nxt_active (v_act)
    );

    // Shadow write lands before the commit check sees it
    always_comb begin
        shd_d   = shd_q;
        wr_fire = cfg_valid && !pending_q;
        if (wr_fire) begin
            unique case (cfg_field_e'(cfg_addr))
                CFG_H_ACTIVE: shd_d.h.active = cfg_data;
                CFG_H_FP:     shd_d.h.fp     = cfg_data;
                CFG_H_SYNC:   shd_d.h.sync   = cfg_data;
                CFG_H_BP:     shd_d.h.bp     = cfg_data;
                CFG_V_ACTIVE: shd_d.v.active = cfg_data;
                CFG_V_FP:     shd_d.v.fp     = cfg_data;
                CFG_V_SYNC:   shd_d.v.sync   = cfg_data;
                CFG_V_BP:     shd_d.v.bp     = cfg_data;
            endcase
        end
    end

    always_comb begin
        commit_try = cfg_commit && !pending_q;
        shd_ok     = axis_ok(shd_d.h) && axis_ok(shd_d.v);
        commit_ok  = commit_try && shd_ok;
        commit_bad = commit_try && !shd_ok;
        apply      = pending_q
                  && ((state_q == ST_STOP) || (h_wrap && v_wrap));
        pending_d  = (pending_q && !apply) || commit_ok;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_STOP: begin
                if (run) begin
                    state_d = pending_d ? ST_PEND : ST_RUN;
                end
            end
            ST_RUN, ST_PEND: begin
                if (!run) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = pending_d ? ST_PEND : ST_RUN;
                end
            end
            default: state_d = ST_STOP;
        endcase
        go = (state_d != ST_STOP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_STOP;
            act_q        <= DEF_SET;
            shd_q        <= DEF_SET;
            pending_q    <= 1'b0;
            err_q        <= 1'b0;
            h_sync       <= 1'b1;
            v_sync       <= 1'b1;
            video_enable <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shd_q     <= shd_d;
            pending_q <= pending_d;
            err_q     <= commit_bad;
            if (apply) begin
                act_q <= shd_q;
            end
            // Decode the position the counters move to this edge
            h_sync       <= !go || h_sn;
            v_sync       <= !go || v_sn;
            video_enable <= go && h_act && v_act;
            line_start   <= go && (h_nxt == '0);
            frame_start  <= go && (h_nxt == '0) && (v_nxt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Randomized bench for vga_timing_sequencer against a
// position/timing-set reference model.
module tb_vga_timing_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        cfg_commit;
    logic        cfg_pending;
    logic        cfg_err;
    logic        h_sync;
    logic        v_sync;
    logic        video_enable;
    logic [11:0] x_idx;
    logic [11:0] y_idx;
    logic        line_start;
    logic        frame_start;

    vga_timing_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_commit   (cfg_commit),
        .cfg_pending  (cfg_pending),
        .cfg_err      (cfg_err),
        .h_sync       (h_sync),
        .v_sync       (v_sync),
        .video_enable (video_enable),
        .x_idx        (x_idx),
        .y_idx        (y_idx),
        .line_start   (line_start),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int defs[8] = '{1920, 88, 44, 148, 1080, 4, 5, 36};
    int m_act[8];
    int m_shd[8];
    bit m_run;
    bit m_pend;
    bit m_err;
    int mx;
    int my;
    int fs_seen;
    int hs_low;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t x=%0d y=%0d)",
                     tag, got, exp, $time, mx, my);
        end
    endtask

    function automatic int tot(int base);
        return m_act[base] + m_act[base+1] + m_act[base+2] + m_act[base+3];
    endfunction

    function automatic bit shd_ok();
        int sh;
        int sv;
        for (int i = 0; i < 8; i++) begin
            if (m_shd[i] == 0) return 1'b0;
        end
        sh = m_shd[0] + m_shd[1] + m_shd[2] + m_shd[3];
        sv = m_shd[4] + m_shd[5] + m_shd[6] + m_shd[7];
        return (sh <= 4095) && (sv <= 4095);
    endfunction

    // Advance the model by one clock using the inputs the DUT just sampled
    task automatic model_step();
        bit apply;
        bit cok;
        int th;
        int tv;
        th = tot(0);
        tv = tot(4);
        if (reset) begin
            m_act  = defs;
            m_shd  = defs;
            m_run  = 1'b0;
            m_pend = 1'b0;
            m_err  = 1'b0;
            mx     = 0;
            my     = 0;
        end else begin
            if (cfg_valid && !m_pend) m_shd[cfg_addr] = int'(cfg_data);
            apply = m_pend && (!m_run || (mx == th - 1 && my == tv - 1));
            cok   = 1'b0;
            m_err = 1'b0;
            if (cfg_commit && !m_pend) begin
                if (shd_ok()) cok = 1'b1;
                else m_err = 1'b1;
            end
            if (m_run && run) begin
                if (mx == th - 1) begin
                    mx = 0;
                    my = (my == tv - 1) ? 0 : my + 1;
                end else begin
                    mx = mx + 1;
                end
            end else begin
                mx = 0;
                my = 0;
            end
            if (apply) m_act = m_shd;
            m_pend = (m_pend && !apply) || cok;
            m_run  = run;
        end
    endtask

    task automatic compare();
        int hs0;
        int hs1;
        int vs0;
        int vs1;
        bit e_hs;
        bit e_vs;
        bit e_ve;
        bit e_ls;
        bit e_fs;
        hs0  = m_act[0] + m_act[1];
        hs1  = hs0 + m_act[2];
        vs0  = m_act[4] + m_act[5];
        vs1  = vs0 + m_act[6];
        e_hs = !(m_run && mx >= hs0 && mx < hs1);
        e_vs = !(m_run && my >= vs0 && my < vs1);
        e_ve = m_run && mx < m_act[0] && my < m_act[4];
        e_ls = m_run && mx == 0;
        e_fs = e_ls && my == 0;
        chk("x_idx", 32'(x_idx), 32'(mx));
        chk("y_idx", 32'(y_idx), 32'(my));
        chk("h_sync", 32'(h_sync), 32'(e_hs));
        chk("v_sync", 32'(v_sync), 32'(e_vs));
        chk("video_enable", 32'(video_enable), 32'(e_ve));
        chk("line_start", 32'(line_start), 32'(e_ls));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("cfg_pending", 32'(cfg_pending), 32'(m_pend));
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        if (frame_start === 1'b1) fs_seen++;
        if (h_sync === 1'b0) hs_low++;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic wr(input int addr, input int data, input bit commit);
        cfg_valid  = 1'b1;
        cfg_addr   = 3'(addr);
        cfg_data   = 12'(data);
        cfg_commit = commit;
        cyc();
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic small_timing();
        wr(0, $urandom_range(4, 24), 1'b0);
        wr(1, $urandom_range(1, 6), 1'b0);
        wr(2, $urandom_range(1, 6), 1'b0);
        wr(3, $urandom_range(1, 6), 1'b0);
        wr(4, $urandom_range(2, 16), 1'b0);
        wr(5, $urandom_range(1, 6), 1'b0);
        wr(6, $urandom_range(1, 6), 1'b0);
        wr(7, $urandom_range(1, 6), 1'b1);
    endtask

    initial begin
        int n;
        int p;
        reset      = 1'b1;
        run        = 1'b0;
        cfg_valid  = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        cfg_commit = 1'b0;
        m_act      = defs;
        m_shd      = defs;
        cyc();
        cyc();
        reset = 1'b0;

        // 1080p defaults: one full line plus change
        run    = 1'b1;
        hs_low = 0;
        for (int i = 0; i < 2300; i++) cyc();
        chk("hsync_low_cycles", 32'(hs_low), 32'd44);

        // rejected commits leave timing alone
        wr(2, 0, 1'b1);
        cyc();
        wr(2, 44, 1'b0);
        wr(0, 4000, 1'b0);
        wr(3, 200, 1'b1);
        cyc();
        wr(0, 1920, 1'b0);
        wr(3, 148, 1'b0);

        // commit then poke while pending, then reset at x=1500
        small_timing();
        wr(1, 9, 1'b0);
        cfg_commit = 1'b1;
        cyc();
        cfg_commit = 1'b0;
        n = 0;
        while (mx != 1500 && n < 3000) begin
            cyc();
            n++;
        end
        chk("reach_x1500", 32'(mx), 32'd1500);
        chk("pend_before_reset", 32'(cfg_pending), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) cyc();

        // apply in STOP, then reassert run
        small_timing();
        run = 1'b0;
        cyc();
        cyc();
        run = 1'b1;
        fs_seen = 0;
        for (int i = 0; i < 3000; i++) cyc();
        chk("frames_after_apply", 32'(fs_seen > 1), 32'd1);

        for (int i = 0; i < 40000; i++) begin
            if (run) run = ($urandom_range(0, 1999) != 0);
            else run = ($urandom_range(0, 7) == 0);
            cfg_valid = ($urandom_range(0, 19) == 0);
            cfg_addr  = 3'($urandom_range(0, 7));
            p = $urandom_range(0, 29);
            if (p == 0) cfg_data = 12'd0;
            else if (p == 1) cfg_data = 12'd4095;
            else if (cfg_addr == 3'd0) cfg_data = 12'($urandom_range(2, 24));
            else if (cfg_addr == 3'd4) cfg_data = 12'($urandom_range(2, 16));
            else cfg_data = 12'($urandom_range(1, 6));
            cfg_commit = ($urandom_range(0, 199) == 0);
            cyc();
        end
        cfg_valid  = 1'b0;
        cfg_commit = 1'b0;

        reset = 1'b1;
        cyc();
        reset = 1'b0;
        run   = 1'b1;
        for (int i = 0; i < 60; i++) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
